// File: rtl/difftest_commit_tracker_pkg.sv
// Shared types and constants for the difftest commit tracker.
package difftest_commit_tracker_pkg;

  localparam int COMMIT_BUS = 32;

  localparam logic [7:0] TRAP_HALT = 8'd0;
  localparam logic [7:0] TRAP_WDOG = 8'd1;
  localparam logic [7:0] TRAP_OVF  = 8'd2;

  // One buffered commit, 102 bits wide.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } commit_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } tracker_state_e;

endpackage

// File: rtl/difftest_commit_tracker_fifo.sv
// Circular commit buffer with CW write ports and OW read ports.
// Pointers carry an extra wrap bit, so count = wr - rd covers the full case.
module difftest_commit_tracker_fifo
  import difftest_commit_tracker_pkg::*;
#(
  parameter int CW    = 2,
  parameter int OW    = 1,
  parameter int DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [CW-1:0]           push_mask_i,
  input  commit_entry_t           push_data_i [CW],
  input  logic [$clog2(DEPTH):0]  pop_cnt_i,
  output logic [$clog2(DEPTH):0]  count_o,
  output commit_entry_t           head_data_o [OW]
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] pushCnt;
  logic [AW-1:0] wrIdx [CW];
  logic [AW-1:0] rdIdx [OW];
  commit_entry_t mem_q [DEPTH];

  // Number of lanes written this cycle and the slot each lane lands in.
  always_comb begin
    pushCnt = '0;
    for (int k = 0; k < CW; k++) begin
      pushCnt  = pushCnt + PW'(push_mask_i[k]);
      wrIdx[k] = wrPtr_q[AW-1:0] + AW'(k);
    end
    wrPtr_d = wrPtr_q + pushCnt;
    rdPtr_d = rdPtr_q + pop_cnt_i;
  end

  // Pointer registers; reset empties the buffer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset: slots are only read once the pointers cover them.
  always_ff @(posedge clock) begin
    for (int k = 0; k < CW; k++) begin
      if (push_mask_i[k]) mem_q[wrIdx[k]] <= push_data_i[k];
    end
  end

  // Expose the oldest OW entries for the drain logic.
  always_comb begin
    for (int j = 0; j < OW; j++) begin
      rdIdx[j]       = rdPtr_q[AW-1:0] + AW'(j);
      head_data_o[j] = mem_q[rdIdx[j]];
    end
  end

  assign count_o = wrPtr_q - rdPtr_q;

endmodule

// File: rtl/difftest_commit_tracker.sv
// Commit tracker: buffers core commits, drains them to difftest channels,
// keeps cycle/instruction counters and latches the end-of-simulation trap.
module difftest_commit_tracker
  import difftest_commit_tracker_pkg::*;
#(
  parameter int          CW         = 2,
  parameter int          OW         = 1,
  parameter int          DEPTH      = 8,
  parameter logic [31:0] TRAP_INSTR = 32'h8000_0000,
  parameter logic [15:0] WDOG_LIMIT = 16'd4096
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [CW-1:0]              cmt_valid,
  input  logic [CW*COMMIT_BUS-1:0]   cmt_pc,
  input  logic [CW*COMMIT_BUS-1:0]   cmt_instr,
  input  logic [CW-1:0]              cmt_wreg,
  input  logic [CW*5-1:0]            cmt_waddr,
  input  logic [CW*COMMIT_BUS-1:0]   cmt_wdata,
  output logic                       cmt_ready,
  output logic [OW-1:0]              out_valid,
  output logic [OW*COMMIT_BUS-1:0]   out_pc,
  output logic [OW*COMMIT_BUS-1:0]   out_instr,
  output logic [OW-1:0]              out_wen,
  output logic [OW*8-1:0]            out_wdest,
  output logic [OW*COMMIT_BUS-1:0]   out_wdata,
  output logic [63:0]                cycle_cnt,
  output logic [63:0]                instr_cnt,
  output logic                       trap_valid,
  output logic [7:0]                 trap_code,
  output logic [31:0]                trap_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  tracker_state_e state_q, state_d;

  commit_entry_t laneIn [CW];
  commit_entry_t headData [OW];
  logic [CW-1:0] pushMask;
  logic          dropped;
  logic [PW-1:0] fifoCount, freeCnt, availCnt, drainCnt, popCnt;
  logic          haltHit, wdogHit;
  logic [31:0]   haltPc;
  logic [15:0]   idle_q, idle_d, idleInc;
  logic [31:0]   lastPc_q, lastPc_d;
  logic [7:0]    trapCode_q, trapCode_d;
  logic [31:0]   trapPc_q, trapPc_d;
  logic [63:0]   cycleCnt_q, instrCnt_q;

  logic [OW-1:0]            outValid_q, outValid_d;
  logic [OW-1:0]            outWen_q, outWen_d;
  logic [OW*COMMIT_BUS-1:0] outPc_q, outPc_d;
  logic [OW*COMMIT_BUS-1:0] outInstr_q, outInstr_d;
  logic [OW*COMMIT_BUS-1:0] outWdata_q, outWdata_d;
  logic [OW*8-1:0]          outWdest_q, outWdest_d;

  // Split the flat lane buses into commit entries.
  always_comb begin
    for (int k = 0; k < CW; k++) begin
      laneIn[k].pc    = cmt_pc[k*COMMIT_BUS +: COMMIT_BUS];
      laneIn[k].instr = cmt_instr[k*COMMIT_BUS +: COMMIT_BUS];
      laneIn[k].wreg  = cmt_wreg[k];
      laneIn[k].waddr = cmt_waddr[k*5 +: 5];
      laneIn[k].wdata = cmt_wdata[k*COMMIT_BUS +: COMMIT_BUS];
    end
  end

  assign freeCnt = PW'(DEPTH) - fifoCount;

  // Admit valid lanes in order while space remains (pre-dequeue count); the rest are dropped.
  always_comb begin
    pushMask = '0;
    dropped  = 1'b0;
    for (int k = 0; k < CW; k++) begin
      if (cmt_valid[k]) begin
        if (PW'(k) < freeCnt) pushMask[k] = 1'b1;
        else                  dropped     = 1'b1;
      end
    end
  end

  difftest_commit_tracker_fifo #(
    .CW   (CW),
    .OW   (OW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push_mask_i(pushMask),
    .push_data_i(laneIn),
    .pop_cnt_i  (popCnt),
    .count_o    (fifoCount),
    .head_data_o(headData)
  );

  // Trap event detection: halt truncates the drain, watchdog fires on an idle cycle.
  always_comb begin
    availCnt = (fifoCount < PW'(OW)) ? fifoCount : PW'(OW);
    drainCnt = availCnt;
    haltHit  = 1'b0;
    haltPc   = '0;
    for (int j = 0; j < OW; j++) begin
      if (!haltHit && (PW'(j) < availCnt) && (headData[j].instr == TRAP_INSTR)) begin
        haltHit  = 1'b1;
        drainCnt = PW'(j + 1);
        haltPc   = headData[j].pc;
      end
    end
    idleInc = (idle_q == 16'hFFFF) ? idle_q : idle_q + 16'd1;
    wdogHit = (availCnt == '0) && (idleInc == WDOG_LIMIT);
  end

  // FSM next state and trap record, priority halt > overflow > watchdog.
  always_comb begin
    state_d    = state_q;
    trapCode_d = trapCode_q;
    trapPc_d   = trapPc_q;
    if (state_q == ST_RUN) begin
      if (haltHit) begin
        state_d    = ST_TRAP;
        trapCode_d = TRAP_HALT;
        trapPc_d   = haltPc;
      end else if (dropped) begin
        state_d    = ST_TRAP;
        trapCode_d = TRAP_OVF;
        trapPc_d   = lastPc_d;
      end else if (wdogHit) begin
        state_d    = ST_TRAP;
        trapCode_d = TRAP_WDOG;
        trapPc_d   = lastPc_d;
      end
    end
  end

  // FSM outputs: accept and drain only while running.
  always_comb begin
    cmt_ready = (state_q == ST_RUN) && (freeCnt >= PW'(CW));
    popCnt    = (state_q == ST_RUN) ? drainCnt : '0;
  end

  // Next values of the output channels, last drained PC and idle counter.
  always_comb begin
    outValid_d = '0;
    outWen_d   = '0;
    outPc_d    = '0;
    outInstr_d = '0;
    outWdata_d = '0;
    outWdest_d = '0;
    lastPc_d   = lastPc_q;
    idle_d     = idle_q;
    for (int j = 0; j < OW; j++) begin
      if (PW'(j) < popCnt) begin
        outValid_d[j]                          = 1'b1;
        outWen_d[j]                            = headData[j].wreg;
        outPc_d[j*COMMIT_BUS +: COMMIT_BUS]    = headData[j].pc;
        outInstr_d[j*COMMIT_BUS +: COMMIT_BUS] = headData[j].instr;
        outWdata_d[j*COMMIT_BUS +: COMMIT_BUS] = headData[j].wdata;
        outWdest_d[j*8 +: 8]                   = {3'b000, headData[j].waddr};
        lastPc_d                               = headData[j].pc;
      end
    end
    if (state_q == ST_RUN) idle_d = (popCnt != '0) ? 16'd0 : idleInc;
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  // Output channels, counters and trap record.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outValid_q <= '0;
      outWen_q   <= '0;
      outPc_q    <= '0;
      outInstr_q <= '0;
      outWdata_q <= '0;
      outWdest_q <= '0;
      lastPc_q   <= '0;
      idle_q     <= '0;
      trapCode_q <= '0;
      trapPc_q   <= '0;
      cycleCnt_q <= '0;
      instrCnt_q <= '0;
    end else begin
      outValid_q <= outValid_d;
      outWen_q   <= outWen_d;
      outPc_q    <= outPc_d;
      outInstr_q <= outInstr_d;
      outWdata_q <= outWdata_d;
      outWdest_q <= outWdest_d;
      lastPc_q   <= lastPc_d;
      idle_q     <= idle_d;
      trapCode_q <= trapCode_d;
      trapPc_q   <= trapPc_d;
      if (state_q == ST_RUN) cycleCnt_q <= cycleCnt_q + 64'd1;
      instrCnt_q <= instrCnt_q + 64'(popCnt);
    end
  end

  assign out_valid  = outValid_q;
  assign out_wen    = outWen_q;
  assign out_pc     = outPc_q;
  assign out_instr  = outInstr_q;
  assign out_wdata  = outWdata_q;
  assign out_wdest  = outWdest_q;
  assign cycle_cnt  = cycleCnt_q;
  assign instr_cnt  = instrCnt_q;
  assign trap_valid = (state_q == ST_TRAP);
  assign trap_code  = trapCode_q;
  assign trap_pc    = trapPc_q;

endmodule

// File: tb/tb_difftest_commit_tracker.sv
// Bench for difftest_commit_tracker: instance A (CW=2, OW=1) with a scoreboard,
// instance B (CW=2, OW=2) for the multi-channel halt case.
module tb_difftest_commit_tracker;

  localparam logic [31:0] TRAP = 32'h8000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  always #5 clock = ~clock;

  logic [1:0]  aValid, aWreg;
  logic [63:0] aPc, aInstr, aWdata;
  logic [9:0]  aWaddr;
  logic        aReady, aTrapValid;
  logic [0:0]  aOutValid, aOutWen;
  logic [31:0] aOutPc, aOutInstr, aOutWdata, aTrapPc;
  logic [7:0]  aOutWdest, aTrapCode;
  logic [63:0] aCycle, aInstrCnt;

  logic [1:0]  bValid, bWreg;
  logic [63:0] bPc, bInstr, bWdata;
  logic [9:0]  bWaddr;
  logic        bReady, bTrapValid;
  logic [1:0]  bOutValid, bOutWen;
  logic [63:0] bOutPc, bOutInstr, bOutWdata;
  logic [15:0] bOutWdest;
  logic [31:0] bTrapPc;
  logic [7:0]  bTrapCode;
  logic [63:0] bCycle, bInstrCnt;

  difftest_commit_tracker #(.CW(2), .OW(1), .DEPTH(8)) dutA (
    .clock(clock), .reset_n(reset_n),
    .cmt_valid(aValid), .cmt_pc(aPc), .cmt_instr(aInstr), .cmt_wreg(aWreg),
    .cmt_waddr(aWaddr), .cmt_wdata(aWdata), .cmt_ready(aReady),
    .out_valid(aOutValid), .out_pc(aOutPc), .out_instr(aOutInstr), .out_wen(aOutWen),
    .out_wdest(aOutWdest), .out_wdata(aOutWdata), .cycle_cnt(aCycle), .instr_cnt(aInstrCnt),
    .trap_valid(aTrapValid), .trap_code(aTrapCode), .trap_pc(aTrapPc)
  );

  difftest_commit_tracker #(.CW(2), .OW(2), .DEPTH(8)) dutB (
    .clock(clock), .reset_n(reset_n),
    .cmt_valid(bValid), .cmt_pc(bPc), .cmt_instr(bInstr), .cmt_wreg(bWreg),
    .cmt_waddr(bWaddr), .cmt_wdata(bWdata), .cmt_ready(bReady),
    .out_valid(bOutValid), .out_pc(bOutPc), .out_instr(bOutInstr), .out_wen(bOutWen),
    .out_wdest(bOutWdest), .out_wdata(bOutWdata), .cycle_cnt(bCycle), .instr_cnt(bInstrCnt),
    .trap_valid(bTrapValid), .trap_code(bTrapCode), .trap_pc(bTrapPc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wdata;
    logic        wen;
    logic [4:0]  waddr;
  } exp_t;

  typedef struct {
    logic [1:0] valid;
    logic       expReady;
  } vec_t;

  exp_t sbQueue [$];
  int   checkCount = 0;
  int   failCount  = 0;

  int          modelCount;
  bit          trapM;
  logic [7:0]  codeM;
  logic [31:0] trapPcM, lastPcM;
  longint      instrM;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    aValid = '0; aPc = '0; aInstr = '0; aWreg = '0; aWaddr = '0; aWdata = '0;
    bValid = '0; bPc = '0; bInstr = '0; bWreg = '0; bWaddr = '0; bWdata = '0;
    tick();
    tick();
    reset_n = 1'b1;
    sbQueue.delete();
    modelCount = 0;
    trapM      = 1'b0;
    codeM      = '0;
    trapPcM    = '0;
    lastPcM    = '0;
    instrM     = 0;
  endtask

  // Drive one cycle on instance A, predict acceptance/drain/trap, then compare.
  task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] pcBase, input logic [31:0] instr0);
    int   nv, acc;
    bit   popM, haltM, dropM;
    exp_t e, outE;
    logic [31:0] pc;
    nv   = int'(valid[0]) + int'(valid[1]);
    acc  = (nv < 8 - modelCount) ? nv : 8 - modelCount;
    popM = !trapM && (modelCount > 0);
    outE = '{default: '0};
    if (popM) outE = sbQueue.pop_front();
    for (int k = 0; k < 2; k++) begin
      pc              = pcBase + 32'(4 * k);
      e.pc            = pc;
      e.instr         = (k == 0) ? instr0 : NOP;
      e.wdata         = pc ^ 32'h5a5a_0f0f;
      e.wen           = (k == 0);
      e.waddr         = pc[6:2];
      aPc[32*k +: 32]    = e.pc;
      aInstr[32*k +: 32] = e.instr;
      aWdata[32*k +: 32] = e.wdata;
      aWreg[k]           = e.wen;
      aWaddr[5*k +: 5]   = e.waddr;
      if (k < acc) sbQueue.push_back(e);
    end
    aValid = valid;
    tick();
    modelCount = modelCount + acc - int'(popM);
    haltM = popM && (outE.instr == TRAP);
    dropM = (nv > acc);
    if (popM) begin
      lastPcM = outE.pc;
      instrM++;
    end
    if (!trapM) begin
      if (haltM) begin
        codeM = 8'd0; trapPcM = outE.pc;
      end else if (dropM) begin
        codeM = 8'd2; trapPcM = lastPcM;
      end
      trapM = haltM || dropM;
    end
    checkOutput("out_valid", 64'(aOutValid), 64'(popM));
    if (popM) begin
      checkOutput("out_pc", 64'(aOutPc), 64'(outE.pc));
      checkOutput("out_instr", 64'(aOutInstr), 64'(outE.instr));
      checkOutput("out_wdata", 64'(aOutWdata), 64'(outE.wdata));
      checkOutput("out_wen", 64'(aOutWen), 64'(outE.wen));
      checkOutput("out_wdest", 64'(aOutWdest), 64'({3'b000, outE.waddr}));
    end
    checkOutput("trap_valid", 64'(aTrapValid), 64'(trapM));
    if (trapM) begin
      checkOutput("trap_code", 64'(aTrapCode), 64'(codeM));
      checkOutput("trap_pc", 64'(aTrapPc), 64'(trapPcM));
    end
    checkOutput("instr_cnt", aInstrCnt, 64'(instrM));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: actual=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    vec_t        vecs [9];
    int          waitCycles;
    logic [63:0] frozen;

    // Fill (honouring ready) then force an overflow at count 7.
    for (int i = 0; i < 6; i++) vecs[i] = '{valid: 2'b11, expReady: 1'b1};
    vecs[6] = '{valid: 2'b11, expReady: 1'b0};
    vecs[7] = '{valid: 2'b00, expReady: 1'b0};
    vecs[8] = '{valid: 2'b00, expReady: 1'b0};

    aValid = '0; aPc = '0; aInstr = '0; aWreg = '0; aWaddr = '0; aWdata = '0;
    bValid = '0; bPc = '0; bInstr = '0; bWreg = '0; bWaddr = '0; bWdata = '0;

    // Reset values while reset is held.
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_ready", 64'(aReady), 64'd1);
    checkOutput("rst_out_valid", 64'(aOutValid), 64'd0);
    checkOutput("rst_out_pc", 64'(aOutPc), 64'd0);
    checkOutput("rst_cycle_cnt", aCycle, 64'd0);
    checkOutput("rst_instr_cnt", aInstrCnt, 64'd0);
    checkOutput("rst_trap_valid", 64'(aTrapValid), 64'd0);
    checkOutput("rst_trap_code", 64'(aTrapCode), 64'd0);
    checkOutput("rst_trap_pc", 64'(aTrapPc), 64'd0);

    $display("[TB] two lanes in, one channel out");
    doReset();
    applyStimulus(2'b11, 32'h1c00_0000, NOP);
    applyStimulus(2'b00, 32'h0, NOP);
    applyStimulus(2'b00, 32'h0, NOP);
    applyStimulus(2'b00, 32'h0, NOP);
    checkOutput("s1_instr_cnt", aInstrCnt, 64'd2);

    $display("[TB] fill to backpressure then overflow");
    doReset();
    for (int i = 0; i < 9; i++) begin
      checkOutput("table_ready", 64'(aReady), 64'(vecs[i].expReady));
      applyStimulus(vecs[i].valid, 32'h1c00_1000 + 32'(8 * i), NOP);
    end
    checkOutput("ovf_code", 64'(aTrapCode), 64'd2);

    $display("[TB] halt on lane 0 with two channels");
    doReset();
    bValid = 2'b11;
    bPc    = {32'h1c00_0014, 32'h1c00_0010};
    bInstr = {NOP, TRAP};
    bWreg  = 2'b10;
    bWaddr = {5'd2, 5'd1};
    bWdata = {32'h2222_2222, 32'h1111_1111};
    tick();
    bValid = 2'b00;
    checkOutput("halt_lat_valid", 64'(bOutValid), 64'd0);
    tick();
    checkOutput("halt_out_valid", 64'(bOutValid), 64'b01);
    checkOutput("halt_out_pc0", 64'(bOutPc[31:0]), 64'h1c00_0010);
    checkOutput("halt_out_pc1", 64'(bOutPc[63:32]), 64'd0);
    checkOutput("halt_out_wdata1", 64'(bOutWdata[63:32]), 64'd0);
    checkOutput("halt_trap_valid", 64'(bTrapValid), 64'd1);
    checkOutput("halt_trap_code", 64'(bTrapCode), 64'd0);
    checkOutput("halt_trap_pc", 64'(bTrapPc), 64'h1c00_0010);
    checkOutput("halt_instr_cnt", bInstrCnt, 64'd1);
    tick();
    checkOutput("halt_after_valid", 64'(bOutValid), 64'd0);
    checkOutput("halt_after_cnt", bInstrCnt, 64'd1);
    checkOutput("halt_hold_pc", 64'(bTrapPc), 64'h1c00_0010);
    checkOutput("halt_ready", 64'(bReady), 64'd0);

    $display("[TB] watchdog after last commit");
    doReset();
    applyStimulus(2'b01, 32'h1c00_0020, NOP);
    applyStimulus(2'b00, 32'h0, NOP);
    aValid     = 2'b00;
    waitCycles = 0;
    while (!aTrapValid && waitCycles < 5000) begin
      tick();
      waitCycles++;
    end
    checkOutput("wdog_latency", 64'(waitCycles), 64'd4096);
    checkOutput("wdog_code", 64'(aTrapCode), 64'd1);
    checkOutput("wdog_pc", 64'(aTrapPc), 64'h1c00_0020);
    frozen = aCycle;
    tick(); tick(); tick();
    checkOutput("wdog_cycle_freeze", aCycle, frozen);
    checkOutput("wdog_out_valid", 64'(aOutValid), 64'd0);

    $display("[TB] reset mid-stream");
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(2'b11, 32'h1c00_2000 + 32'(8 * i), NOP);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 64'(aReady), 64'd1);
    checkOutput("mid_rst_out_valid", 64'(aOutValid), 64'd0);
    checkOutput("mid_rst_out_pc", 64'(aOutPc), 64'd0);
    checkOutput("mid_rst_cycle", aCycle, 64'd0);
    checkOutput("mid_rst_instr", aInstrCnt, 64'd0);
    doReset();
    checkOutput("post_rst_cycle0", aCycle, 64'd0);
    applyStimulus(2'b00, 32'h0, NOP);
    applyStimulus(2'b00, 32'h0, NOP);
    applyStimulus(2'b00, 32'h0, NOP);
    checkOutput("post_rst_cycle3", aCycle, 64'd3);
    checkOutput("post_rst_ready", 64'(aReady), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
